// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states, access check.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3W  = 3;

  localparam logic [F3W-1:0] F3_B  = 3'b000;
  localparam logic [F3W-1:0] F3_H  = 3'b001;
  localparam logic [F3W-1:0] F3_W  = 3'b010;
  localparam logic [F3W-1:0] F3_BU = 3'b100;
  localparam logic [F3W-1:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Illegal width code or address not aligned to the access width.
  function automatic logic access_err(input logic [F3W-1:0] f3, input logic [1:0] lane);
    logic err;
    case (f3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = lane[0];
      F3_W:        err = (lane != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [F3W-1:0]  funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] load_word,
  input  logic [XLEN-1:0] base_word,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_word
);

  logic [4:0]  bshift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to a full word.
  always_comb begin
    bshift   = {lane, 3'b000};
    byte_sel = load_word[bshift +: 8];
    half_sel = lane[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = load_word;
      default: load_data = '0;
    endcase
  end

  // Overlay the store data onto the addressed lane(s) of the old word.
  always_comb begin
    store_word = base_word;
    case (funct3)
      F3_B, F3_BU: store_word[bshift +: 8] = wdata[7:0];
      F3_H, F3_HU: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default:     store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, read-modify-write for sub-word stores.
module lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [F3W-1:0]  req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_q
);

  state_t          state, state_nxt;
  logic            cap_we;
  logic [F3W-1:0]  cap_funct3;
  logic [XLEN-1:0] cap_addr;
  logic [XLEN-1:0] cap_wdata;
  logic [XLEN-1:0] rmw_word;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;
  logic            accept;
  logic            req_err;

  assign accept  = req_valid && (state == ST_IDLE);
  assign req_err = access_err(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3     (cap_funct3),
    .lane       (cap_addr[1:0]),
    .load_word  (mem_q),
    .base_word  (rmw_word),
    .wdata      (cap_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: errors skip memory, SW writes directly, everything else reads first.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                         state_nxt = ST_RESP;
          else if (req_we && req_funct3 == F3_W) state_nxt = ST_WRITE;
          else                                 state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = cap_we ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register and captured request.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    mem_addr   = '0;
    mem_data   = '0;
    mem_we     = 1'b0;
    if (state == ST_READ || state == ST_LATCH || state == ST_WRITE)
      mem_addr = {cap_addr[31:2], 2'b00};
    if (state == ST_WRITE) begin
      mem_we   = 1'b1;
      mem_data = store_word;
    end
  end

  // Request capture and old-word latch for read-modify-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we     <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rmw_word   <= '0;
    end else begin
      if (accept) begin
        cap_we     <= req_we;
        cap_funct3 <= req_funct3;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
      end
      if (state == ST_LATCH) rmw_word <= mem_q;
    end
  end

  // Response registers, updated only on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state_nxt == ST_RESP && state != ST_RESP) begin
      resp_err   <= (state == ST_IDLE);
      resp_rdata <= (state == ST_LATCH && !cap_we) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a one-cycle-latency word memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt;
  logic [31:0] we_addr;
  logic [31:0] we_data;
  int          lat;
  int          resp_seen;
  int          busy_ready;
  logic [7:0]  rdy_bits;
  logic [7:0]  rv_bits;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_q      (mem_q)
  );

  always #5 clk = ~clk;

  // Memory: read data returned one cycle after the address; writes on mem_we.
  always @(posedge clk) begin
    mem_q <= mem[mem_addr[9:2]];
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_data;
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and return the number of cycles from acceptance to resp_valid.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int cycles);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    we_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (resp_valid) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h41] = 32'h8899AABB;   // 0x104
    mem[8'h42] = 32'hDEADBEEF;   // 0x108
    mem_q = 32'h0;
    we_cnt = 0; we_addr = 0; we_data = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_ready",    32'(req_ready),  32'd1);
    chk("rst_rvalid",   32'(resp_valid), 32'd0);
    chk("rst_err",      32'(resp_err),   32'd0);
    chk("rst_rdata",    resp_rdata,      32'h0);
    chk("rst_mem_addr", mem_addr,        32'h0);
    chk("rst_mem_data", mem_data,        32'h0);
    chk("rst_mem_we",   32'(mem_we),     32'd0);
    rst = 1'b0;

    issue(1'b0, 3'b010, 32'h104, 32'h0, lat);
    chk("lw_lat",   32'(lat),        32'd3);
    chk("lw_rdata", resp_rdata,      32'h8899AABB);
    chk("lw_err",   32'(resp_err),   32'd0);
    chk("lw_nowe",  32'(we_cnt),     32'd0);

    issue(1'b0, 3'b000, 32'h107, 32'h0, lat);
    chk("lb_rdata", resp_rdata, 32'hFFFFFF88);
    issue(1'b0, 3'b100, 32'h107, 32'h0, lat);
    chk("lbu_rdata", resp_rdata, 32'h00000088);
    issue(1'b0, 3'b001, 32'h106, 32'h0, lat);
    chk("lh_rdata", resp_rdata, 32'hFFFF8899);
    issue(1'b0, 3'b101, 32'h104, 32'h0, lat);
    chk("lhu_rdata", resp_rdata, 32'h0000AABB);
    issue(1'b0, 3'b000, 32'h104, 32'h0, lat);
    chk("lb0_rdata", resp_rdata, 32'hFFFFFFBB);

    issue(1'b1, 3'b001, 32'h10A, 32'h00001234, lat);
    chk("sh_lat",   32'(lat),    32'd4);
    chk("sh_wecnt", 32'(we_cnt), 32'd1);
    chk("sh_addr",  we_addr,     32'h108);
    chk("sh_data",  we_data,     32'h1234BEEF);
    chk("sh_rdata", resp_rdata,  32'h0);

    issue(1'b1, 3'b000, 32'h105, 32'h000000C3, lat);
    chk("sb_lat",   32'(lat),    32'd4);
    chk("sb_addr",  we_addr,     32'h104);
    chk("sb_data",  we_data,     32'h8899C3BB);

    issue(1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, lat);
    chk("sw_lat",   32'(lat),    32'd2);
    chk("sw_wecnt", 32'(we_cnt), 32'd1);
    chk("sw_addr",  we_addr,     32'h10C);
    chk("sw_data",  we_data,     32'hCAFEF00D);

    issue(1'b0, 3'b010, 32'h102, 32'h0, lat);
    chk("lwmis_lat",  32'(lat),      32'd1);
    chk("lwmis_err",  32'(resp_err), 32'd1);
    chk("lwmis_nowe", 32'(we_cnt),   32'd0);
    issue(1'b0, 3'b011, 32'h100, 32'h0, lat);
    chk("f3bad_lat",  32'(lat),      32'd1);
    chk("f3bad_err",  32'(resp_err), 32'd1);
    chk("f3bad_nowe", 32'(we_cnt),   32'd0);
    repeat (3) @(negedge clk);
    chk("err_hold", 32'(resp_err), 32'd1);

    // SB with reset asserted while the old word is being latched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h110; req_wdata = 32'h55;
    we_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_err",   32'(resp_err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    chk("rstmid_nowe",   32'(we_cnt),    32'd0);
    chk("rstmid_nresp",  32'(resp_seen), 32'd0);
    chk("rstmid_ready2", 32'(req_ready), 32'd1);

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
    rdy_bits = 8'h0; rv_bits = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      rdy_bits[i] = req_ready;
      rv_bits[i]  = resp_valid;
    end
    req_valid = 1'b0;
    chk("b2b_ready", 32'(rdy_bits), 32'h11);
    chk("b2b_rvalid", 32'(rv_bits), 32'h88);
    busy_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid && req_ready) busy_ready++;
    end
    chk("b2b_rdata", resp_rdata, 32'h8899C3BB);
    chk("b2b_overlap", 32'(busy_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
